// File: rtl/ghost_mode_ctrl.sv
// Central ghost mode controller: scatter/chase schedule, frightened episodes,
// per-ghost state tracking, chained ghost-eat scoring and the Pac-Man death flag.
module ghost_mode_ctrl #(
  parameter int NUM_GHOSTS    = 4,
  parameter int FPS           = 60,
  parameter int SCATTER_LONG  = 7,
  parameter int SCATTER_SHORT = 5,
  parameter int LONG_ROUNDS   = 2,
  parameter int CHASE_SECS    = 20,
  parameter int TOTAL_ROUNDS  = 4,
  parameter int FRIGHT_SECS   = 10,
  parameter int FLASH_SECS    = 3,
  parameter int FLASH_PERIOD  = 10
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    soft_reset,
  input  logic                    start,
  input  logic                    energizer,
  input  logic [NUM_GHOSTS-1:0]   collide,
  input  logic [NUM_GHOSTS-1:0]   home,
  output logic [1:0]              global_mode,
  output logic [3*NUM_GHOSTS-1:0] ghost_state,
  output logic [NUM_GHOSTS-1:0]   reverse,
  output logic                    flash,
  output logic                    fright_active,
  output logic                    pacman_dead,
  output logic [15:0]             score_add,
  output logic                    score_valid
);

  localparam int FRIGHT_FRAMES = FRIGHT_SECS * FPS;
  localparam int FLASH_FRAMES  = FLASH_SECS * FPS;
  localparam int MAX_SECS = (CHASE_SECS > SCATTER_LONG) ?
                            ((CHASE_SECS > SCATTER_SHORT) ? CHASE_SECS : SCATTER_SHORT) :
                            ((SCATTER_LONG > SCATTER_SHORT) ? SCATTER_LONG : SCATTER_SHORT);
  localparam int FW = (FPS > 1) ? $clog2(FPS) : 1;
  localparam int SW = $clog2(MAX_SECS + 1);
  localparam int RW = (TOTAL_ROUNDS > 1) ? $clog2(TOTAL_ROUNDS) : 1;
  localparam int CW = $clog2(FRIGHT_FRAMES + 1);

  typedef enum logic [1:0] {G_WAIT = 2'd0, G_SCATTER = 2'd1, G_CHASE = 2'd2} gmode_t;
  typedef enum logic [2:0] {
    S_WAIT = 3'd0, S_SCATTER = 3'd1, S_CHASE = 3'd2, S_FRIGHT = 3'd3, S_DEAD = 3'd4
  } gstate_t;

  gmode_t                mode_q, mode_d;
  gstate_t               gs_q [NUM_GHOSTS];
  gstate_t               gs_d [NUM_GHOSTS];
  logic [NUM_GHOSTS-1:0] rev_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic [SW-1:0]         sec_q, sec_d;
  logic [RW-1:0]         round_q, round_d;
  logic [CW-1:0]         fright_q, fright_d;
  logic [1:0]            chain_q, chain_d;
  logic [15:0]           score_d;
  logic                  eat_any, lethal, flash_d;
  logic                  live, tick, frame_wrap, go_chase, go_scatter, go_start, glob_tr;
  logic                  ener, fright_end;
  int                    scatter_secs;

  assign global_mode = mode_q;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_pack
    assign ghost_state[3*g +: 3] = gs_q[g];
  end

  // Schedule timing, fright countdown and every ghost's next state for this frame.
  // Ghost updates are ordered: global transition, fright end, energizer, then collide/home,
  // so a ghost frightened this frame is eaten rather than lethal.
  always_comb begin
    gstate_t st;
    logic    rv;
    live         = !pacman_dead;
    tick         = live && (fright_q == '0) && (mode_q != G_WAIT);
    frame_wrap   = (int'(frame_q) == FPS - 1);
    scatter_secs = (int'(round_q) < LONG_ROUNDS) ? SCATTER_LONG : SCATTER_SHORT;
    go_chase     = tick && (mode_q == G_SCATTER) && frame_wrap &&
                   (int'(sec_q) + 1 == scatter_secs);
    go_scatter   = tick && (mode_q == G_CHASE) && (int'(round_q) < TOTAL_ROUNDS - 1) &&
                   frame_wrap && (int'(sec_q) + 1 == CHASE_SECS);
    go_start     = live && (mode_q == G_WAIT) && start;
    glob_tr      = go_chase || go_scatter;

    mode_d = mode_q;
    if (go_chase) mode_d = G_CHASE;
    else if (go_scatter || go_start) mode_d = G_SCATTER;

    frame_d = frame_q;
    sec_d   = sec_q;
    if (glob_tr || go_start) begin
      frame_d = '0;
      sec_d   = '0;
    end else if (tick) begin
      if (frame_wrap) begin
        frame_d = '0;
        sec_d   = sec_q + 1'b1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
    round_d = go_scatter ? round_q + 1'b1 : round_q;

    ener       = live && energizer && (mode_q != G_WAIT);
    fright_end = live && !ener && (fright_q == CW'(1));
    fright_d   = fright_q;
    if (ener) fright_d = CW'(FRIGHT_FRAMES);
    else if (live && (fright_q != '0)) fright_d = fright_q - 1'b1;

    chain_d = ener ? 2'd0 : chain_q;
    score_d = '0;
    eat_any = 1'b0;
    lethal  = 1'b0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      st = gs_q[i];
      rv = 1'b0;
      if (live) begin
        if (glob_tr && (st == S_SCATTER || st == S_CHASE)) begin
          st = gstate_t'({1'b0, mode_d});
          rv = 1'b1;
        end
        if (go_start && st == S_WAIT) st = S_SCATTER;
        if (fright_end && st == S_FRIGHT) st = gstate_t'({1'b0, mode_d});
        if (ener && (st == S_SCATTER || st == S_CHASE)) begin
          st = S_FRIGHT;
          rv = 1'b1;
        end
        if (collide[i]) begin
          if (st == S_FRIGHT) begin
            st      = S_DEAD;
            score_d = score_d + (16'd200 << chain_d);
            eat_any = 1'b1;
            if (chain_d != 2'd3) chain_d = chain_d + 2'd1;
          end else if (st == S_SCATTER || st == S_CHASE) begin
            lethal = 1'b1;
          end
        end else if (home[i] && gs_q[i] == S_DEAD) begin
          st = gstate_t'({1'b0, mode_d});
        end
      end
      gs_d[i]  = st;
      rev_d[i] = rv;
    end

    flash_d = (fright_d != '0) && (int'(fright_d) <= FLASH_FRAMES) &&
              (((FLASH_FRAMES - int'(fright_d)) / FLASH_PERIOD) % 2 == 1);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset || soft_reset) begin
      mode_q        <= G_WAIT;
      for (int i = 0; i < NUM_GHOSTS; i++) gs_q[i] <= S_WAIT;
      frame_q       <= '0;
      sec_q         <= '0;
      round_q       <= '0;
      fright_q      <= '0;
      chain_q       <= '0;
      reverse       <= '0;
      flash         <= 1'b0;
      fright_active <= 1'b0;
      pacman_dead   <= 1'b0;
      score_add     <= '0;
      score_valid   <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      for (int i = 0; i < NUM_GHOSTS; i++) gs_q[i] <= gs_d[i];
      frame_q       <= frame_d;
      sec_q         <= sec_d;
      round_q       <= round_d;
      fright_q      <= fright_d;
      chain_q       <= chain_d;
      reverse       <= rev_d;
      flash         <= flash_d;
      fright_active <= (fright_d != '0);
      pacman_dead   <= pacman_dead | lethal;
      score_add     <= eat_any ? score_d : 16'd0;
      score_valid   <= eat_any;
    end
  end

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Directed testbench for ghost_mode_ctrl: schedule, fright/flash, eating chain,
// death freeze and same-frame energizer/collide ordering.
module tb_ghost_mode_ctrl;

  logic        frame_clk = 1'b0;
  logic        Reset, soft_reset, start, energizer;
  logic [3:0]  collide, home;
  logic [1:0]  global_mode;
  logic [11:0] ghost_state;
  logic [3:0]  reverse;
  logic        flash, fright_active, pacman_dead, score_valid;
  logic [15:0] score_add;

  int vectors = 0;
  int miscompares = 0;

  ghost_mode_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .soft_reset(soft_reset), .start(start),
    .energizer(energizer), .collide(collide), .home(home),
    .global_mode(global_mode), .ghost_state(ghost_state), .reverse(reverse),
    .flash(flash), .fright_active(fright_active), .pacman_dead(pacman_dead),
    .score_add(score_add), .score_valid(score_valid)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic logic [11:0] pack4(input logic [2:0] g3, g2, g1, g0);
    return {g3, g2, g1, g0};
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge frame_clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_energizer();
    energizer = 1'b1;
    step();
    energizer = 1'b0;
  endtask

  // Phase lasting len frames from its entry edge, ending in a reversing transition.
  task automatic run_phase(input int len, input logic [1:0] from_m, input logic [1:0] to_m,
                           input string name);
    repeat (len - 1) step();
    vectors++;
    if (global_mode !== from_m) begin
      miscompares++;
      $display("[TB] FAIL %s_hold: global_mode=%0d expected %0d", name, global_mode, from_m);
    end
    step();
    vectors++;
    if (global_mode !== to_m || reverse !== 4'b1111 || ghost_state !== {4{1'b0, to_m}}) begin
      miscompares++;
      $display("[TB] FAIL %s_end: mode=%0d rev=%b gs=%h expected mode=%0d rev=1111 gs=%h",
               name, global_mode, reverse, ghost_state, to_m, {4{1'b0, to_m}});
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    start = 1'b1;
    step();
    Reset = 1'b0;
    start = 1'b0;
    vectors++;
    if ({global_mode, ghost_state, reverse, flash, fright_active, pacman_dead,
         score_add, score_valid} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: mode=%0d gs=%h rev=%b fl=%b fa=%b pd=%b sa=%0d sv=%b expected all 0",
               global_mode, ghost_state, reverse, flash, fright_active, pacman_dead,
               score_add, score_valid);
    end
    pulse_energizer();
    vectors++;
    if (fright_active !== 1'b0 || ghost_state !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL wait_energizer: fa=%b gs=%h expected fa=0 gs=000", fright_active, ghost_state);
    end
  endtask

  task automatic test_schedule();
    do_reset();
    pulse_start();
    vectors++;
    if (global_mode !== 2'd1 || ghost_state !== pack4(1, 1, 1, 1) || reverse !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL start: mode=%0d gs=%h rev=%b expected 1 249 0000",
               global_mode, ghost_state, reverse);
    end
    run_phase(420, 2'd1, 2'd2, "scatter0");
    step();
    vectors++;
    if (reverse !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reverse_pulse: rev=%b expected 0000", reverse);
    end
    run_phase(1199, 2'd2, 2'd1, "chase0");
    run_phase(420, 2'd1, 2'd2, "scatter1");
    run_phase(1200, 2'd2, 2'd1, "chase1");
    run_phase(300, 2'd1, 2'd2, "scatter2");
    run_phase(1200, 2'd2, 2'd1, "chase2");
    run_phase(300, 2'd1, 2'd2, "scatter3");
    repeat (5000) step();
    vectors++;
    if (global_mode !== 2'd2 || reverse !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL permanent_chase: mode=%0d rev=%b expected 2 0000", global_mode, reverse);
    end
  endtask

  task automatic test_fright();
    do_reset();
    pulse_start();
    run_phase(420, 2'd1, 2'd2, "f_scatter");
    repeat (300) step();
    pulse_energizer();
    vectors++;
    if (ghost_state !== pack4(3, 3, 3, 3) || reverse !== 4'b1111 || fright_active !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fright_enter: gs=%h rev=%b fa=%b expected 6db 1111 1",
               ghost_state, reverse, fright_active);
    end
    repeat (429) step();
    vectors++;
    if (flash !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flash_171: flash=%b expected 0", flash);
    end
    step();
    vectors++;
    if (flash !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flash_170: flash=%b expected 1", flash);
    end
    repeat (9) step();
    vectors++;
    if (flash !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flash_161: flash=%b expected 1", flash);
    end
    step();
    vectors++;
    if (flash !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flash_160: flash=%b expected 0", flash);
    end
    repeat (159) step();
    vectors++;
    if (fright_active !== 1'b1 || ghost_state !== pack4(3, 3, 3, 3)) begin
      miscompares++;
      $display("[TB] FAIL fright_last: fa=%b gs=%h expected 1 6db", fright_active, ghost_state);
    end
    step();
    vectors++;
    if (fright_active !== 1'b0 || ghost_state !== pack4(2, 2, 2, 2) || reverse !== 4'b0000 ||
        flash !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fright_exit: fa=%b gs=%h rev=%b fl=%b expected 0 492 0000 0",
               fright_active, ghost_state, reverse, flash);
    end
    run_phase(899, 2'd2, 2'd1, "f_resume");
  endtask

  task automatic test_eat_chain();
    do_reset();
    pulse_start();
    repeat (10) step();
    pulse_energizer();
    collide = 4'b0110;
    step();
    collide = 4'b0000;
    vectors++;
    if (ghost_state !== pack4(3, 4, 4, 3) || score_add !== 16'd600 || score_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL eat_pair: gs=%h sa=%0d sv=%b expected %h 600 1",
               ghost_state, score_add, score_valid, pack4(3, 4, 4, 3));
    end
    step();
    vectors++;
    if (score_add !== 16'd0 || score_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL score_idle: sa=%0d sv=%b expected 0 0", score_add, score_valid);
    end
    collide = 4'b1000;
    step();
    collide = 4'b0000;
    vectors++;
    if (score_add !== 16'd800 || ghost_state !== pack4(4, 4, 4, 3)) begin
      miscompares++;
      $display("[TB] FAIL eat_third: sa=%0d gs=%h expected 800 %h", score_add, ghost_state,
               pack4(4, 4, 4, 3));
    end
    collide = 4'b0001;
    step();
    collide = 4'b0000;
    vectors++;
    if (score_add !== 16'd1600 || ghost_state !== pack4(4, 4, 4, 4)) begin
      miscompares++;
      $display("[TB] FAIL eat_fourth: sa=%0d gs=%h expected 1600 924", score_add, ghost_state);
    end
    home = 4'b0010;
    step();
    home = 4'b0000;
    vectors++;
    if (ghost_state !== pack4(4, 4, 1, 4)) begin
      miscompares++;
      $display("[TB] FAIL home_return: gs=%h expected %h", ghost_state, pack4(4, 4, 1, 4));
    end
    pulse_energizer();
    vectors++;
    if (ghost_state !== pack4(4, 4, 3, 4) || reverse !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL dead_not_fright: gs=%h rev=%b expected %h 0010",
               ghost_state, reverse, pack4(4, 4, 3, 4));
    end
    collide = 4'b0010;
    step();
    collide = 4'b0000;
    vectors++;
    if (score_add !== 16'd200 || score_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL chain_restart: sa=%0d sv=%b expected 200 1", score_add, score_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse_start();
    pulse_energizer();
    collide = 4'b1111;
    step();
    collide = 4'b0000;
    vectors++;
    if (score_add !== 16'd3000 || ghost_state !== pack4(4, 4, 4, 4)) begin
      miscompares++;
      $display("[TB] FAIL eat_all: sa=%0d gs=%h expected 3000 924", score_add, ghost_state);
    end
  endtask

  task automatic test_death();
    do_reset();
    pulse_start();
    run_phase(420, 2'd1, 2'd2, "d_scatter");
    repeat (5) step();
    collide = 4'b0001;
    step();
    collide = 4'b0000;
    vectors++;
    if (pacman_dead !== 1'b1 || ghost_state !== pack4(2, 2, 2, 2) || score_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL death: pd=%b gs=%h sv=%b expected 1 492 0",
               pacman_dead, ghost_state, score_valid);
    end
    pulse_energizer();
    vectors++;
    if (fright_active !== 1'b0 || ghost_state !== pack4(2, 2, 2, 2) || reverse !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL dead_energizer: fa=%b gs=%h rev=%b expected 0 492 0000",
               fright_active, ghost_state, reverse);
    end
    repeat (1300) step();
    vectors++;
    if (global_mode !== 2'd2 || pacman_dead !== 1'b1 || reverse !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL dead_frozen: mode=%0d pd=%b rev=%b expected 2 1 0000",
               global_mode, pacman_dead, reverse);
    end
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    vectors++;
    if ({global_mode, ghost_state, reverse, flash, fright_active, pacman_dead,
         score_add, score_valid} !== '0) begin
      miscompares++;
      $display("[TB] FAIL soft_reset: mode=%0d gs=%h pd=%b expected all 0",
               global_mode, ghost_state, pacman_dead);
    end
  endtask

  task automatic test_same_frame();
    do_reset();
    pulse_start();
    repeat (3) step();
    energizer = 1'b1;
    collide   = 4'b0100;
    step();
    energizer = 1'b0;
    collide   = 4'b0000;
    vectors++;
    if (ghost_state !== pack4(3, 4, 3, 3) || score_add !== 16'd200 || pacman_dead !== 1'b0 ||
        reverse !== 4'b1111) begin
      miscompares++;
      $display("[TB] FAIL same_frame: gs=%h sa=%0d pd=%b rev=%b expected %h 200 0 1111",
               ghost_state, score_add, pacman_dead, reverse, pack4(3, 4, 3, 3));
    end
    home = 4'b0100;
    step();
    home = 4'b0000;
    vectors++;
    if (ghost_state !== pack4(3, 1, 3, 3)) begin
      miscompares++;
      $display("[TB] FAIL same_frame_home: gs=%h expected %h", ghost_state, pack4(3, 1, 3, 3));
    end
  endtask

  initial begin
    Reset      = 1'b0;
    soft_reset = 1'b0;
    start      = 1'b0;
    energizer  = 1'b0;
    collide    = 4'b0000;
    home       = 4'b0000;
    step();
    test_reset();
    test_schedule();
    test_fright();
    test_eat_chain();
    test_back_to_back();
    test_death();
    test_same_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ghost_mode_ctrl.md
Name: ghost_mode_ctrl

Overview:
- Centralised, parametrised mode controller for all ghosts.
- Runs the global scatter/chase schedule and the frightened episode with end-of-fright flashing.
- Tracks per-ghost WAIT/SCATTER/CHASE/FRIGHT/DEAD state, produces chained ghost-eat scoring (200/400/800/1600) and the Pac-Man death flag.
- Ghost movement modules consume ghost_state, reverse and flash; the score module consumes score_add/score_valid.

Parameters:
- NUM_GHOSTS, 4, number of ghost channels.
- FPS, 60, frames per second (frame_clk ticks per timer second).
- SCATTER_LONG, 7, scatter seconds in rounds below LONG_ROUNDS.
- SCATTER_SHORT, 5, scatter seconds in later rounds.
- LONG_ROUNDS, 2, count of rounds using SCATTER_LONG.
- CHASE_SECS, 20, chase seconds per round.
- TOTAL_ROUNDS, 4, scatter phases; chase is permanent after the last.
- FRIGHT_SECS, 10, frightened duration in seconds.
- FLASH_SECS, 3, final seconds of fright during which flash is active.
- FLASH_PERIOD, 10, frames per flash half-cycle.

Ports:
- frame_clk  in  1  frame-rate clock.
- Reset  in  1  synchronous, active-high.
- soft_reset  in  1  synchronous life-lost/new-map restart; same effect as Reset.
- start  in  1  level-start pulse.
- energizer  in  1  power-pellet eaten pulse.
- collide  in  NUM_GHOSTS  per-ghost Pac-Man overlap, this frame.
- home  in  NUM_GHOSTS  per-ghost "DEAD eyes reached house".
- global_mode  out  2  0=WAIT, 1=SCATTER, 2=CHASE.
- ghost_state  out  3*NUM_GHOSTS  per ghost: 0=WAIT, 1=SCATTER, 2=CHASE, 3=FRIGHT, 4=DEAD.
- reverse  out  NUM_GHOSTS  one-frame pulse: ghost must reverse direction.
- flash  out  1  frightened sprite alternate (white) select.
- fright_active  out  1  fright counter nonzero.
- pacman_dead  out  1  sticky death flag.
- score_add  out  16  points awarded this frame.
- score_valid  out  1  score_add valid pulse.

Behaviour:
- Reset values (Reset or soft_reset): all outputs 0; global_mode=WAIT; all ghost_state=WAIT; round=0; frame, second and fright counters 0; eat chain 0.
- Reset and soft_reset are sampled on frame_clk and override all other inputs in that frame.
- All outputs are registered: an input in frame N produces its effect on outputs after edge N.
- Global FSM:
  - WAIT -> SCATTER on start.
  - SCATTER -> CHASE when seconds == (round<LONG_ROUNDS ? SCATTER_LONG : SCATTER_SHORT).
  - CHASE -> SCATTER when seconds == CHASE_SECS and round < TOTAL_ROUNDS-1; round increments on this transition.
  - When round == TOTAL_ROUNDS-1, chase never ends.
  - Frame and second counters clear on every global transition.
- Timers: frame counter wraps at FPS-1, then seconds increments. Schedule timers pause while fright_active=1 or pacman_dead=1.
- Global transition effect: every ghost in SCATTER/CHASE follows global_mode and gets reverse=1 for one frame. FRIGHT, DEAD and WAIT ghosts are unaffected.
- WAIT->SCATTER moves all WAIT ghosts to SCATTER with no reverse.
- energizer, only when global_mode != WAIT:
  - Fright counter loads FRIGHT_SECS*FPS and eat chain clears.
  - Every ghost in SCATTER/CHASE -> FRIGHT with reverse=1.
  - Ghosts already FRIGHT stay FRIGHT with no reverse; DEAD ghosts are unaffected.
  - A re-trigger during fright reloads the counter.
- Fright counter decrements each frame while nonzero. On the frame it reaches 0, FRIGHT ghosts revert to global_mode with no reverse.
- flash: 1 when remaining <= FLASH_SECS*FPS and ((FLASH_SECS*FPS - remaining) / FLASH_PERIOD) is odd; 0 otherwise.
- Same-frame ordering: energizer is applied before collide. A ghost turned FRIGHT that frame is eaten, not lethal.
- Collision, per ghost:
  - FRIGHT: ghost -> DEAD; award 200 << chain, then chain++ (saturates at 3).
  - Several ghosts eaten in one frame are processed lowest index first with successive chain values. score_add is their sum and score_valid=1.
  - SCATTER/CHASE: pacman_dead <= 1, which is sticky until reset.
  - WAIT/DEAD: ignored.
  - If any lethal collision occurs in a frame, that frame's eats still score.
- DEAD with home[i]=1 -> global_mode. A DEAD ghost never enters FRIGHT.
- pacman_dead=1 freezes all counters and ghost states. energizer and collide are ignored until reset.
- score_add is 0 whenever score_valid=0.

Test Plan:
- Reset, start, no other input -> SCATTER for 7*60 frames, then CHASE with reverse=4'b1111 for 1 frame; CHASE for 1200 frames, then SCATTER and round=1.
- Run to round 3 -> scatter lasts 300 frames in rounds 2–3; after round 3 scatter, CHASE persists past 5000 frames.
- energizer in CHASE at second 5 -> all ghosts FRIGHT with reverse pulse; schedule frozen 600 frames; first flash high at remaining=170; ghosts return to CHASE with second counter resuming at 5.
- During fright, collide=4'b0110 in one frame -> ghosts 1,2 DEAD, score_add=600; later collide[3] -> score_add=800; collide[0] -> 1600; new energizer, then eat -> 200.
- collide[0] in CHASE -> pacman_dead=1 next frame; states frozen; energizer ignored; soft_reset -> all outputs 0, WAIT.
- energizer and collide[2] in the same frame with ghost 2 in SCATTER -> ghost 2 DEAD, score_add=200, pacman_dead stays 0; home[2] -> ghost 2 SCATTER.
